// File: rtl/video_window.sv
// Output-window calculator: fits a source aspect ratio or an absolute size into the
// HDMI raster and centres it. The results are held until the next computation finishes.
module video_window (
    input  logic        CLK_VIDEO,
    input  logic        RESET,
    input  logic [11:0] HDMI_WIDTH,
    input  logic [11:0] HDMI_HEIGHT,
    input  logic [12:0] VIDEO_ARX,
    input  logic [12:0] VIDEO_ARY,
    output logic [11:0] WIN_HMIN,
    output logic [11:0] WIN_HMAX,
    output logic [11:0] WIN_VMIN,
    output logic [11:0] WIN_VMAX,
    output logic        WIN_VALID,
    output logic        WIN_UPD,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_MUL, S_DIV, S_CHECK, S_PLACE
    } state_t;

    state_t      state;
    logic        stale;
    logic        second;
    logic [11:0] s_w, s_h;
    logic [12:0] s_arx, s_ary;
    logic [11:0] width, height;
    logic [11:0] divisor, rem;
    logic [23:0] quot;
    logic [4:0]  count;

    function automatic logic [11:0] sat12(input logic [23:0] q);
        return (q > 24'd4095) ? 12'hFFF : q[11:0];
    endfunction

    function automatic logic [11:0] nz(input logic [11:0] v);
        return (v == 12'd0) ? 12'd1 : v;
    endfunction

    function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? a : b;
    endfunction

    logic        start;
    logic [12:0] rem_sh;
    logic        rem_ge;
    logic [11:0] rem_next;
    logic [23:0] product;
    logic [11:0] q_sat;
    logic [11:0] eff_h;
    logic [11:0] h_span, v_span;
    logic [11:0] new_hmin, new_hmax, new_vmin, new_vmax;
    logic        hdmi_zero;

    assign start = stale || (HDMI_WIDTH != s_w) || (HDMI_HEIGHT != s_h) ||
                   (VIDEO_ARX != s_arx) || (VIDEO_ARY != s_ary);

    // One restoring step: the remainder stays below the divisor, so 12 bits hold it.
    assign rem_sh   = {rem, quot[23]};
    assign rem_ge   = rem_sh >= {1'b0, divisor};
    assign rem_next = rem_ge ? 12'(rem_sh - {1'b0, divisor}) : rem_sh[11:0];

    assign product = second ? ({12'd0, s_w} * {12'd0, s_ary[11:0]})
                            : ({12'd0, s_h} * {12'd0, s_arx[11:0]});

    // The second-pass height comes straight out of the divider on entry to PLACE.
    assign q_sat     = sat12(quot);
    assign eff_h     = second ? nz(q_sat) : height;
    assign hdmi_zero = (s_w == 12'd0) || (s_h == 12'd0);
    assign h_span    = s_w - width;
    assign v_span    = s_h - eff_h;
    assign new_hmin  = hdmi_zero ? 12'd0 : (h_span >> 1);
    assign new_hmax  = hdmi_zero ? 12'd0 : 12'((h_span >> 1) + width - 12'd1);
    assign new_vmin  = hdmi_zero ? 12'd0 : (v_span >> 1);
    assign new_vmax  = hdmi_zero ? 12'd0 : 12'((v_span >> 1) + eff_h - 12'd1);

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            state     <= S_IDLE;
            stale     <= 1'b1;
            second    <= 1'b0;
            s_w       <= '0;
            s_h       <= '0;
            s_arx     <= '0;
            s_ary     <= '0;
            width     <= '0;
            height    <= '0;
            divisor   <= '0;
            rem       <= '0;
            quot      <= '0;
            count     <= '0;
            WIN_HMIN  <= '0;
            WIN_HMAX  <= '0;
            WIN_VMIN  <= '0;
            WIN_VMAX  <= '0;
            WIN_VALID <= 1'b0;
            WIN_UPD   <= 1'b0;
        end else begin
            WIN_UPD <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        s_w   <= HDMI_WIDTH;
                        s_h   <= HDMI_HEIGHT;
                        s_arx <= VIDEO_ARX;
                        s_ary <= VIDEO_ARY;
                        stale <= 1'b0;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    second <= 1'b0;
                    if (hdmi_zero) begin
                        state <= S_PLACE;
                    end else if (s_arx[12]) begin
                        width  <= nz(min12(s_arx[11:0], s_w));
                        height <= nz(min12(s_ary[11:0], s_h));
                        state  <= S_PLACE;
                    end else if ((s_arx[11:0] == 12'd0) || (s_ary[11:0] == 12'd0)) begin
                        width  <= s_w;
                        height <= s_h;
                        state  <= S_PLACE;
                    end else begin
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    quot    <= product;
                    rem     <= '0;
                    divisor <= second ? s_arx[11:0] : s_ary[11:0];
                    count   <= 5'd23;
                    state   <= S_DIV;
                end
                S_DIV: begin
                    rem   <= rem_next;
                    quot  <= {quot[22:0], rem_ge};
                    count <= count - 5'd1;
                    if (count == 5'd0) begin
                        state <= second ? S_PLACE : S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Too wide for the raster: pin the width and derive the height instead.
                    if (q_sat > s_w) begin
                        width  <= s_w;
                        second <= 1'b1;
                        state  <= S_MUL;
                    end else begin
                        width  <= nz(q_sat);
                        height <= s_h;
                        state  <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    WIN_HMIN  <= new_hmin;
                    WIN_HMAX  <= new_hmax;
                    WIN_VMIN  <= new_vmin;
                    WIN_VMAX  <= new_vmax;
                    WIN_VALID <= !hdmi_zero;
                    WIN_UPD   <= (new_hmin != WIN_HMIN) || (new_hmax != WIN_HMAX) ||
                                 (new_vmin != WIN_VMIN) || (new_vmax != WIN_VMAX);
                    height    <= eff_h;
                    second    <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_window.sv
// Bench for video_window: directed scenarios plus random inputs checked against
// an arithmetic model of the window rules.
module tb_video_window;

    logic        clk;
    logic        rst;
    logic [11:0] hdmi_w, hdmi_h;
    logic [12:0] arx, ary;
    logic [11:0] hmin, hmax, vmin, vmax;
    logic        valid, upd, busy;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int first_hmax = -1;
    int prev_hmin, prev_hmax, prev_vmin, prev_vmax;

    video_window dut (
        .CLK_VIDEO  (clk),
        .RESET      (rst),
        .HDMI_WIDTH (hdmi_w),
        .HDMI_HEIGHT(hdmi_h),
        .VIDEO_ARX  (arx),
        .VIDEO_ARY  (ary),
        .WIN_HMIN   (hmin),
        .WIN_HMAX   (hmax),
        .WIN_VMIN   (vmin),
        .WIN_VMAX   (vmax),
        .WIN_VALID  (valid),
        .WIN_UPD    (upd),
        .BUSY       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (upd) begin
            if (upd_cnt == 0) first_hmax = int'(hmax);
            upd_cnt++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int w, input int h, input int ax, input int ay,
                         output int e_hmin, output int e_hmax, output int e_vmin,
                         output int e_vmax, output int e_valid);
        int ww, hh, nx, ny;
        nx = ax % 4096;
        ny = ay % 4096;
        if (w == 0 || h == 0) begin
            e_hmin = 0; e_hmax = 0; e_vmin = 0; e_vmax = 0; e_valid = 0;
            return;
        end
        if (ax >= 4096) begin
            ww = (nx < w) ? nx : w;
            hh = (ny < h) ? ny : h;
        end else if (nx == 0 || ny == 0) begin
            ww = w;
            hh = h;
        end else begin
            ww = (h * nx) / ny;
            if (ww > 4095) ww = 4095;
            hh = h;
            if (ww > w) begin
                ww = w;
                hh = (w * ny) / nx;
                if (hh > 4095) hh = 4095;
            end
        end
        if (ww == 0) ww = 1;
        if (hh == 0) hh = 1;
        e_hmin  = (w - ww) / 2;
        e_hmax  = e_hmin + ww - 1;
        e_vmin  = (h - hh) / 2;
        e_vmax  = e_vmin + hh - 1;
        e_valid = 1;
    endtask

    task automatic drive(input int w, input int h, input int ax, input int ay);
        @(negedge clk);
        hdmi_w = 12'(w);
        hdmi_h = 12'(h);
        arx    = 13'(ax);
        ary    = 13'(ay);
        upd_cnt = 0;
        first_hmax = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one input set, let it settle, then compare against the model.
    task automatic run_case(input string tag, input int w, input int h, input int ax, input int ay);
        int e_hmin, e_hmax, e_vmin, e_vmax, e_valid, e_upd;
        model(w, h, ax, ay, e_hmin, e_hmax, e_vmin, e_vmax, e_valid);
        e_upd = (e_hmin != prev_hmin || e_hmax != prev_hmax ||
                 e_vmin != prev_vmin || e_vmax != prev_vmax) ? 1 : 0;
        drive(w, h, ax, ay);
        wait_cycles(70);
        check({tag, "_hmin"}, int'(hmin), e_hmin);
        check({tag, "_hmax"}, int'(hmax), e_hmax);
        check({tag, "_vmin"}, int'(vmin), e_vmin);
        check({tag, "_vmax"}, int'(vmax), e_vmax);
        check({tag, "_valid"}, int'(valid), e_valid);
        check({tag, "_upd"}, upd_cnt, e_upd);
        check({tag, "_busy"}, int'(busy), 0);
        prev_hmin = e_hmin; prev_hmax = e_hmax;
        prev_vmin = e_vmin; prev_vmax = e_vmax;
    endtask

    task automatic clear_prev();
        prev_hmin = 0; prev_hmax = 0; prev_vmin = 0; prev_vmax = 0;
    endtask

    initial begin
        rst = 1'b1;
        hdmi_w = 12'd1920; hdmi_h = 12'd1080; arx = 13'd4; ary = 13'd3;
        clear_prev();
        wait_cycles(3);
        check("rst_hmin", int'(hmin), 0);
        check("rst_hmax", int'(hmax), 0);
        check("rst_vmin", int'(vmin), 0);
        check("rst_vmax", int'(vmax), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_busy", int'(busy), 0);

        // First computation after reset starts on its own with unchanged inputs.
        @(negedge clk);
        rst = 1'b0;
        upd_cnt = 0;
        wait_cycles(70);
        check("r43_hmin", int'(hmin), 240);
        check("r43_hmax", int'(hmax), 1679);
        check("r43_vmin", int'(vmin), 0);
        check("r43_vmax", int'(vmax), 1079);
        check("r43_valid", int'(valid), 1);
        check("r43_upd", upd_cnt, 1);
        prev_hmin = 240; prev_hmax = 1679; prev_vmin = 0; prev_vmax = 1079;

        run_case("r64x27", 1920, 1080, 64, 27);
        check("r64x27_vmin_c", int'(vmin), 135);
        check("r64x27_vmax_c", int'(vmax), 944);

        // Absolute size must land within three clock edges.
        drive(1920, 1080, 'h1500, 'h13C0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abs_hmin", int'(hmin), 320);
        check("abs_hmax", int'(hmax), 1599);
        check("abs_vmin", int'(vmin), 60);
        check("abs_vmax", int'(vmax), 1019);
        check("abs_upd", int'(upd), 1);
        check("abs_busy", int'(busy), 0);
        prev_hmin = 320; prev_hmax = 1599; prev_vmin = 60; prev_vmax = 1019;

        run_case("clamp", 1280, 720, 'h17D0, 'h1320);
        check("clamp_hmax_c", int'(hmax), 1279);
        run_case("full", 1280, 720, 0, 0);
        check("full_vmax_c", int'(vmax), 719);
        check("full_noupd", upd_cnt, 0);

        // Change the ratio while the first division is running.
        drive(1920, 1080, 16, 9);
        wait_cycles(10);
        check("mid_busy", int'(busy), 1);
        ary = 13'd12;
        wait_cycles(130);
        check("mid_first_hmax", first_hmax, 1919);
        check("mid_upd_cnt", upd_cnt, 2);
        check("mid_hmin", int'(hmin), 240);
        check("mid_hmax", int'(hmax), 1679);
        check("mid_vmax", int'(vmax), 1079);
        prev_hmin = 240; prev_hmax = 1679; prev_vmin = 0; prev_vmax = 1079;

        // Reset in the middle of a division.
        drive(1920, 1080, 3, 2);
        wait_cycles(10);
        rst = 1'b1;
        @(negedge clk);
        check("rmid_busy", int'(busy), 0);
        check("rmid_valid", int'(valid), 0);
        check("rmid_hmin", int'(hmin), 0);
        check("rmid_hmax", int'(hmax), 0);
        check("rmid_vmax", int'(vmax), 0);
        rst = 1'b0;
        upd_cnt = 0;
        wait_cycles(70);
        check("rrel_hmin", int'(hmin), 150);
        check("rrel_hmax", int'(hmax), 1769);
        check("rrel_valid", int'(valid), 1);
        check("rrel_upd", upd_cnt, 1);
        prev_hmin = 150; prev_hmax = 1769; prev_vmin = 0; prev_vmax = 1079;

        run_case("zero_w", 0, 720, 4, 3);
        run_case("after_zero", 800, 600, 16, 9);

        for (int i = 0; i < 24; i++) begin
            int w, h, ax, ay, mode;
            w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4095));
            h = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4095));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin
                    ax = 4096 + int'($urandom_range(0, 4095));
                    ay = int'($urandom_range(0, 8191));
                end
                1: begin
                    ax = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 4095));
                    ay = (ax == 0) ? int'($urandom_range(0, 4095)) : 0;
                end
                2: begin
                    ax = int'($urandom_range(1, 64));
                    ay = int'($urandom_range(1, 64));
                end
                default: begin
                    ax = int'($urandom_range(1, 4095));
                    ay = 4096 * int'($urandom_range(0, 1)) + int'($urandom_range(1, 4095));
                end
            endcase
            run_case($sformatf("rnd%0d", i), w, h, ax, ay);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_window.md
VIDEO_WINDOW -- requirements
Module: video_window

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- CLK_VIDEO  in  1  video clock; the only clock in the block.
- RESET  in  1  synchronous, active-high reset.
- HDMI_WIDTH  in  12  active output width in pixels.
- HDMI_HEIGHT  in  12  active output height in lines.
- VIDEO_ARX  in  13  bit12=1: absolute width in [11:0]; bit12=0: aspect numerator.
- VIDEO_ARY  in  13  bit12=1: absolute height in [11:0]; bit12=0: aspect denominator.
- WIN_HMIN  out  12  first active output column.
- WIN_HMAX  out  12  last active output column.
- WIN_VMIN  out  12  first active output line.
- WIN_VMAX  out  12  last active output line.
- WIN_VALID  out  1  window outputs hold a completed result.
- WIN_UPD  out  1  one-cycle pulse when the window outputs change.
- BUSY  out  1  a computation is in progress.

Function
REQ-002 Inputs SHALL be captured into shadow registers when a computation starts; all arithmetic SHALL use only the shadow values.
REQ-003 In IDLE, any mismatch between the live inputs and the shadows SHALL start a computation on the next cycle; the first computation after reset SHALL start unconditionally.
REQ-004 State machine: IDLE -> SELECT -> (MUL -> DIV -> CHECK -> [MUL -> DIV]) or direct -> PLACE -> IDLE.
REQ-005 BUSY SHALL be 1 in every state other than IDLE.
REQ-006 Full-screen case (bit12=0 and ARX[11:0]=0 or ARY[11:0]=0): width=HDMI_WIDTH, height=HDMI_HEIGHT.
REQ-007 Absolute case (VIDEO_ARX[12]=1): width=min(ARX[11:0],HDMI_WIDTH), height=min(ARY[11:0],HDMI_HEIGHT); no division is performed.
REQ-008 Ratio case:
- width = floor(HDMI_HEIGHT*ARX/ARY), height = HDMI_HEIGHT.
- If that width exceeds HDMI_WIDTH: width=HDMI_WIDTH and height = floor(HDMI_WIDTH*ARY/ARX).
REQ-009 Products SHALL be 24-bit; a shared iterative restoring divider SHALL compute a 24-bit/12-bit quotient at 1 bit per cycle (24 cycles).
REQ-010 A quotient above 4095 SHALL saturate to 4095 before comparison.
REQ-011 A computed width or height of 0 SHALL be forced to 1.
REQ-012 PLACE:
- hmin = (HDMI_WIDTH-width)>>1, hmax = hmin+width-1.
- vmin = (HDMI_HEIGHT-height)>>1, vmax = vmin+height-1.
- All four outputs update in the same cycle.
REQ-013 In the PLACE-exit cycle, WIN_VALID SHALL go to 1, and WIN_UPD SHALL pulse only if any of the four values differs from its previous value.
REQ-014 Outputs SHALL hold their previous values throughout a computation, with no partial updates.
REQ-015 Input changes during a computation SHALL NOT abort it; the mismatch is detected on return to IDLE and a new computation follows.
REQ-016 Latency from start to outputs-valid: absolute and full-screen cases = 3 cycles; ratio case ≤ 60 cycles.
REQ-017 HDMI_WIDTH=0 or HDMI_HEIGHT=0 SHALL yield all outputs 0 with WIN_VALID=0.

Reset
REQ-018 While RESET=1, state SHALL return to IDLE from any state on the next clock edge, including mid-division.
REQ-019 Reset values: WIN_* = 0, WIN_VALID=0, WIN_UPD=0, BUSY=0, divider cleared, shadows marked stale.

Verification
REQ-020 Bench SHALL cover:
- 1920x1080, ARX=4, ARY=3 -> HMIN=240, HMAX=1679, VMIN=0, VMAX=1079; one WIN_UPD pulse.
- 1920x1080, ARX=64, ARY=27 (width overflow) -> HMIN=0, HMAX=1919, VMIN=135, VMAX=944.
- 1920x1080, ARX=0x1500 (abs 1280), ARY=0x13C0 (abs 960) -> 320/1599/60/1019 within 3 cycles.
- 1280x720, abs 2000x800 (clamped) -> 0/1279/0/719; ARX=0 -> 0/1279/0/719, no WIN_UPD pulse on the second, identical result.
- ARY changed mid-division -> first result still completes, then a second computation runs; final outputs match the new inputs.
- RESET asserted mid-division -> next cycle BUSY=0, WIN_VALID=0, WIN_*=0; after release a fresh computation starts automatically.
